stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Single-clock, valid/ready streaming FIFO.
- Consumes the wrap-bit pointer counter: one write-pointer instance and one read-pointer instance, each ADDR_WIDTH+1 bits (low bits index the array, MSB toggles on each wrap).
- Decouples producer and consumer stages in the accelerator datapath (feature-map and weight streams).
- Supports any DEPTH ≥ 2, including non-powers of two.

Parameters:
- DATA_WIDTH, 16: payload width in bits.
- DEPTH, 16: number of storage entries; ADDR_WIDTH = $clog2(DEPTH).
- AFULL_THRESH, DEPTH-2: almost_full asserts when count ≥ AFULL_THRESH.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_data, input, DATA_WIDTH: write payload.
- in_valid, input, 1: producer has data.
- in_ready, output, 1: FIFO can accept a word.
- out_data, output, DATA_WIDTH: head-of-queue payload.
- out_valid, output, 1: head word present.
- out_ready, input, 1: consumer takes the word.
- count, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- almost_full, output, 1: count ≥ AFULL_THRESH.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - wr_ptr = rd_ptr = 0; count = 0.
  - out_valid = 0; in_ready = 1; almost_full = 0 (if AFULL_THRESH > 0).
- Storage array is not reset. out_data is don't-care while out_valid = 0.
- Transfer qualifiers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A transfer occurs only on a rising edge where both signals of a pair are high.
- Pointers: each counts 0..DEPTH-1 in its low bits. At DEPTH-1 the low bits return to 0 and the MSB toggles. Increment only on push (wr_ptr) or pop (rd_ptr).
- Full/empty:
  - empty = (wr_ptr == rd_ptr), all ADDR_WIDTH+1 bits.
  - full = low bits equal and MSBs differ.
  - in_ready = ~full; out_valid = ~empty.
  - All combinational from registered pointers, so no comb path from in_valid/out_ready to the ready/valid outputs.
- Write: on push, mem[wr_ptr_low] <= in_data.
- Read (first-word-fall-through): out_data = mem[rd_ptr_low], combinational from the array.
- Latency: a word pushed at edge N is visible with out_valid = 1 after edge N. No same-cycle bypass when empty.
- count register:
  - +1 on push only; -1 on pop only.
  - Unchanged when both or neither occur.
  - Must always equal occupancy derived from the pointers.
- almost_full: registered compare of the next count value, so it updates on the same edge as count.
- Simultaneous push+pop:
  - Mid-range: both pointers advance, count unchanged.
  - When full: push is blocked (in_ready = 0); a pop that edge frees a slot, and in_ready rises after the edge.
  - When empty: pop is impossible (out_valid = 0).
- Data ordering: strict FIFO; no drop, no duplication, across any number of wraps.
- Protocol hold rules:
  - Producer holds in_data/in_valid until accepted.
  - FIFO holds out_data/out_valid stable while out_ready = 0.
- Reset mid-operation: asserting rst_n = 0 immediately clears pointers, count and almost_full, so out_valid drops and in_ready rises asynchronously. Stored contents are discarded logically.
- Overflow/underflow are unreachable by construction. Assertions in the bench check count ≤ DEPTH and no push while full.

Test Plan:
- Reset then idle, DEPTH=16: out_valid=0, in_ready=1, count=0, almost_full=0 for 10 cycles.
- Fill: push 0x0001..0x0010 back-to-back with out_ready=0.
  - After the 16th edge: count=16, in_ready=0.
  - almost_full=1 from count=14.
  - A 17th in_valid is not accepted.
- Drain: out_ready=1 on the full FIFO: out_data sequence 0x0001..0x0010 on consecutive edges, then out_valid=0, count=0.
- DEPTH=5 wrap: 23 words pushed/popped with random valid/ready stalls.
  - Output order matches input.
  - wr_ptr MSB toggles after words 5, 10, 15, 20.
- Simultaneous push+pop at count=3: count stays 3 for 8 consecutive cycles; data order preserved.
- Async reset at count=7, mid-clock: out_valid and count go to 0 before the next edge. A subsequent push of 0xBEEF appears as out_data with out_valid=1 one edge later.

Source files
------------

// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through valid/ready FIFO; a word pushed on edge N shows on out_* after edge N.
// Backpressure: in_ready = ~full and out_valid = ~empty, both decoded from registered wrap-bit pointers only.
module stream_fifo_ptr #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  output logic [ADDR_WIDTH:0]   ptr
);
  localparam int                    PW   = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  // Low bits count 0..DEPTH-1; the MSB flips on every wrap so full and empty stay distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr[ADDR_WIDTH-1:0] == LAST) begin
        ptr <= {~ptr[ADDR_WIDTH], {ADDR_WIDTH{1'b0}}};
      end else begin
        ptr <= ptr + PW'(1);
      end
    end
  end
endmodule

module stream_fifo #(
  parameter  int DATA_WIDTH   = 16,
  parameter  int DEPTH        = 16,
  parameter  int AFULL_THRESH = DEPTH - 2,
  localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
);
  localparam int                CW     = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_T = CW'(AFULL_THRESH);
  localparam logic              AF_RST = (AFULL_THRESH <= 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  stream_fifo_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  stream_fifo_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  assign out_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // almost_full compares the next count so both registers move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      almost_full <= AF_RST;
    end else begin
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_T);
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a DEPTH=16 instance for fill/drain/reset and a DEPTH=5 instance for wrapping.
module tb_stream_fifo;
  logic        clk;
  logic        rst_n;

  logic [15:0] in16_data;
  logic        in16_valid;
  logic        in16_ready;
  logic [15:0] out16_data;
  logic        out16_valid;
  logic        out16_ready;
  logic [4:0]  count16;
  logic        af16;

  logic [15:0] in5_data;
  logic        in5_valid;
  logic        in5_ready;
  logic [15:0] out5_data;
  logic        out5_valid;
  logic        out5_ready;
  logic [3:0]  count5;
  logic        af5;

  int checks = 0;
  int errors = 0;

  stream_fifo #(.DATA_WIDTH(16), .DEPTH(16)) dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in16_data),
    .in_valid    (in16_valid),
    .in_ready    (in16_ready),
    .out_data    (out16_data),
    .out_valid   (out16_valid),
    .out_ready   (out16_ready),
    .count       (count16),
    .almost_full (af16)
  );

  stream_fifo #(.DATA_WIDTH(16), .DEPTH(5)) dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in5_data),
    .in_valid    (in5_valid),
    .in_ready    (in5_ready),
    .out_data    (out5_data),
    .out_valid   (out5_valid),
    .out_ready   (out5_ready),
    .count       (count5),
    .almost_full (af5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Structural invariants sampled every cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("mon16_count_le_depth", 32'(count16 <= 5'd16), 32'd1);
      check("mon16_no_push_full", 32'(in16_valid & in16_ready & (count16 == 5'd16)), 32'd0);
      check("mon16_ready_vs_count", 32'(in16_ready), 32'(count16 != 5'd16));
      check("mon16_valid_vs_count", 32'(out16_valid), 32'(count16 != 5'd0));
      check("mon5_count_le_depth", 32'(count5 <= 4'd5), 32'd1);
      check("mon5_ready_vs_count", 32'(in5_ready), 32'(count5 != 4'd5));
      check("mon5_afull", 32'(af5), 32'(count5 >= 4'd3));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] q[$];
    int sent;
    int rcvd;
    int cyc;
    int mcount;
    logic exp_push;
    logic exp_pop;

    rst_n = 1'b0;
    in16_data = '0; in16_valid = 1'b0; out16_ready = 1'b0;
    in5_data = '0;  in5_valid = 1'b0;  out5_ready = 1'b0;

    #1;
    check("rst_out_valid", 32'(out16_valid), 32'd0);
    check("rst_in_ready", 32'(in16_ready), 32'd1);
    check("rst_count", 32'(count16), 32'd0);
    check("rst_afull", 32'(af16), 32'd0);
    #11 rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_out_valid", 32'(out16_valid), 32'd0);
      check("idle_in_ready", 32'(in16_ready), 32'd1);
      check("idle_count", 32'(count16), 32'd0);
      check("idle_afull", 32'(af16), 32'd0);
    end

    // Fill 0x0001..0x0010 with the consumer stalled
    for (int k = 1; k <= 16; k++) begin
      in16_valid = 1'b1;
      in16_data  = 16'(k);
      @(negedge clk);
      check("fill_count", 32'(count16), 32'(k));
      check("fill_afull", 32'(af16), 32'(k >= 14));
      check("fill_in_ready", 32'(in16_ready), 32'(k < 16));
      check("fill_out_valid", 32'(out16_valid), 32'd1);
      check("fill_head_hold", 32'(out16_data), 32'h0001);
    end
    in16_data = 16'h0011;
    @(negedge clk);
    check("full_17th_count", 32'(count16), 32'd16);
    check("full_17th_in_ready", 32'(in16_ready), 32'd0);
    check("full_17th_head", 32'(out16_data), 32'h0001);
    in16_valid = 1'b0;

    // Drain the full FIFO
    out16_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("drain_out_valid", 32'(out16_valid), 32'd1);
      check("drain_out_data", 32'(out16_data), 32'(k));
      check("drain_count", 32'(count16), 32'(17 - k));
      check("drain_afull", 32'(af16), 32'((17 - k) >= 14));
      @(negedge clk);
    end
    check("drained_out_valid", 32'(out16_valid), 32'd0);
    check("drained_count", 32'(count16), 32'd0);
    check("drained_in_ready", 32'(in16_ready), 32'd1);
    check("drained_afull", 32'(af16), 32'd0);
    out16_ready = 1'b0;

    // Simultaneous push+pop at count=3
    for (int k = 0; k < 3; k++) begin
      in16_valid = 1'b1;
      in16_data  = 16'h0100 + 16'(k);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      check("pp_count", 32'(count16), 32'd3);
      check("pp_out_data", 32'(out16_data), 32'h0100 + 32'(i));
      in16_valid  = 1'b1;
      in16_data   = 16'h0103 + 16'(i);
      out16_ready = 1'b1;
      @(negedge clk);
    end
    check("pp_count_after", 32'(count16), 32'd3);
    in16_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("pp_tail_data", 32'(out16_data), 32'h0108 + 32'(j));
      @(negedge clk);
    end
    check("pp_empty_count", 32'(count16), 32'd0);
    check("pp_empty_valid", 32'(out16_valid), 32'd0);
    out16_ready = 1'b0;

    // DEPTH=5 wrap with random stalls against a queue model
    sent = 0; rcvd = 0; cyc = 0; mcount = 0;
    while (rcvd < 23 && cyc < 2000) begin
      if (!in5_valid && sent < 23) begin
        in5_valid = ($urandom_range(0, 3) != 0);
        in5_data  = 16'hA000 + 16'(sent);
      end
      out5_ready = ($urandom_range(0, 4) < 3);
      exp_push = in5_valid && (mcount < 5);
      exp_pop  = out5_ready && (mcount > 0);
      check("wrap_in_ready", 32'(in5_ready), 32'(mcount < 5));
      check("wrap_out_valid", 32'(out5_valid), 32'(mcount > 0));
      if (exp_pop) check("wrap_out_data", 32'(out5_data), 32'(q[0]));
      @(negedge clk);
      cyc++;
      if (exp_push) begin
        q.push_back(in5_data);
        sent++;
        mcount++;
        in5_valid = 1'b0;
        check("wrap_wr_msb", 32'(dut5.wr_ptr[3]), 32'((sent / 5) % 2));
      end
      if (exp_pop) begin
        void'(q.pop_front());
        rcvd++;
        mcount--;
      end
      check("wrap_count", 32'(count5), 32'(mcount));
    end
    check("wrap_received", 32'(rcvd), 32'd23);
    check("wrap_end_count", 32'(count5), 32'd0);
    in5_valid  = 1'b0;
    out5_ready = 1'b0;

    // Async reset at count=7, asserted between edges
    for (int k = 0; k < 7; k++) begin
      in16_valid = 1'b1;
      in16_data  = 16'h0200 + 16'(k);
      @(negedge clk);
    end
    in16_valid = 1'b0;
    check("prerst_count", 32'(count16), 32'd7);
    check("prerst_head", 32'(out16_data), 32'h0200);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out16_valid), 32'd0);
    check("arst_count", 32'(count16), 32'd0);
    check("arst_in_ready", 32'(in16_ready), 32'd1);
    check("arst_afull", 32'(af16), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    in16_valid = 1'b1;
    in16_data  = 16'hBEEF;
    @(negedge clk);
    in16_valid = 1'b0;
    check("post_rst_valid", 32'(out16_valid), 32'd1);
    check("post_rst_data", 32'(out16_data), 32'hBEEF);
    check("post_rst_count", 32'(count16), 32'd1);
    out16_ready = 1'b1;
    @(negedge clk);
    check("post_rst_drained", 32'(out16_valid), 32'd0);
    out16_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
